// File: rtl/score_display_ctrl.sv
`default_nettype none
//============================================================================
// Module  : score_display_ctrl
// Brief   : Chooses which score to show and converts it to BCD with a
//           sequential shift-add-3 engine. Define SCORE_FLASH_EN to blink
//           the final score.
// Revision: 1.0
//============================================================================
module score_display_ctrl #(
   parameter int HOLD_TICKS = 6,
   parameter int MAX_SCORE  = 140
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       goodColl,
   input  logic       badColl,
   input  logic [7:0] currScore,
   input  logic [7:0] highScore,
   input  logic       tick,
   output logic [3:0] bcd_ones,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_hundreds,
   output logic       blank,
   output logic       showing_high,
   output logic       busy,
   output logic       game_over
);

   localparam logic [7:0] c_MAX_SCORE  = 8'(MAX_SCORE);
   localparam logic [3:0] c_HOLD_TICKS = 4'(HOLD_TICKS);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_FLASH, S_HIGH} disp_state_t;
   typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT, C_DONE} conv_state_t;

   disp_state_t r_state, r_prev_state, w_state_nxt;
   logic [7:0]  r_final, w_final_nxt;
   logic [3:0]  r_tick_cnt, w_tick_cnt_nxt;
   logic        r_blank, w_blank_nxt;
   logic [7:0]  w_src;
   logic        w_src_high;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state      <= S_IDLE;
         r_prev_state <= S_IDLE;
         r_final      <= 8'd0;
         r_tick_cnt   <= 4'd0;
         r_blank      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev_state <= r_state;
         r_final      <= w_final_nxt;
         r_tick_cnt   <= w_tick_cnt_nxt;
         r_blank      <= w_blank_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_final_nxt    = r_final;
      w_tick_cnt_nxt = r_tick_cnt;
      w_blank_nxt    = r_blank;
      case (r_state)
         S_IDLE, S_HIGH: begin
            if (goodColl) w_state_nxt = S_PLAY;
         end
         S_PLAY: begin
            // badColl takes priority over a simultaneous goodColl
            if (badColl || (currScore >= c_MAX_SCORE)) begin
               w_state_nxt    = S_FLASH;
               w_final_nxt    = currScore;
               w_tick_cnt_nxt = 4'd0;
               w_blank_nxt    = 1'b0;
            end
         end
         S_FLASH: begin
            if (goodColl) begin
               w_state_nxt    = S_PLAY;
               w_tick_cnt_nxt = 4'd0;
               w_blank_nxt    = 1'b0;
            end else if (tick) begin
               if (r_tick_cnt + 4'd1 == c_HOLD_TICKS) begin
                  w_state_nxt    = S_HIGH;
                  w_tick_cnt_nxt = 4'd0;
                  w_blank_nxt    = 1'b0;
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + 4'd1;
`ifdef SCORE_FLASH_EN
                  w_blank_nxt    = ~r_blank;
`else
                  w_blank_nxt    = 1'b0;
`endif
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_src      = highScore;
      w_src_high = 1'b1;
      if (r_state == S_PLAY) begin
         w_src      = currScore;
         w_src_high = 1'b0;
      end else if (r_state == S_FLASH) begin
         w_src      = r_final;
         w_src_high = 1'b0;
      end
   end

   assign blank     = r_blank;
   assign game_over = (r_state == S_FLASH) || (r_state == S_HIGH);

   conv_state_t r_cstate, w_cstate_nxt;
   logic [7:0]  r_last;
   logic        r_last_high;
   logic        r_pending;
   logic        r_first;
   logic [19:0] r_sh;
   logic [19:0] w_adj;
   logic [19:0] w_step;
   logic [2:0]  r_bit;
   logic        w_req;
   logic        w_capture;

   // r_first forces the post-reset conversion even when highScore is 0
   assign w_req = r_first || (r_state != r_prev_state) || (w_src != r_last);
   assign busy  = (r_cstate != C_IDLE);

   always_comb begin
      w_adj = r_sh;
      if (w_adj[11:8]  >= 4'd5) w_adj[11:8]  = w_adj[11:8]  + 4'd3;
      if (w_adj[15:12] >= 4'd5) w_adj[15:12] = w_adj[15:12] + 4'd3;
      if (w_adj[19:16] >= 4'd5) w_adj[19:16] = w_adj[19:16] + 4'd3;
      w_step = {w_adj[18:0], 1'b0};
   end

   always_comb begin
      w_cstate_nxt = r_cstate;
      w_capture    = 1'b0;
      case (r_cstate)
         C_IDLE: begin
            if (w_req) begin
               w_cstate_nxt = C_LOAD;
               w_capture    = 1'b1;
            end
         end
         C_LOAD:  w_cstate_nxt = C_SHIFT;
         C_SHIFT: if (r_bit == 3'd7) w_cstate_nxt = C_DONE;
         C_DONE: begin
            if (r_pending || w_req) begin
               w_cstate_nxt = C_LOAD;
               w_capture    = 1'b1;
            end else begin
               w_cstate_nxt = C_IDLE;
            end
         end
         default: w_cstate_nxt = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_cstate     <= C_IDLE;
         r_last       <= 8'd0;
         r_last_high  <= 1'b1;
         r_pending    <= 1'b0;
         r_first      <= 1'b1;
         r_sh         <= 20'd0;
         r_bit        <= 3'd0;
         bcd_ones     <= 4'd0;
         bcd_tens     <= 4'd0;
         bcd_hundreds <= 4'd0;
         showing_high <= 1'b1;
      end else begin
         r_cstate <= w_cstate_nxt;
         if (w_capture) begin
            r_last      <= w_src;
            r_last_high <= w_src_high;
            r_first     <= 1'b0;
            r_pending   <= 1'b0;
         end else if (w_req && busy) begin
            r_pending <= 1'b1;
         end
         if (r_cstate == C_LOAD) begin
            r_sh  <= {12'd0, r_last};
            r_bit <= 3'd0;
         end else if (r_cstate == C_SHIFT) begin
            r_sh  <= w_step;
            r_bit <= r_bit + 3'd1;
            // publish all digits at once on the final shift
            if (r_bit == 3'd7) begin
               bcd_hundreds <= w_step[19:16];
               bcd_tens     <= w_step[15:12];
               bcd_ones     <= w_step[11:8];
               showing_high <= r_last_high;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
//============================================================================
// Module  : tb_score_display_ctrl
// Brief   : Directed self-checking bench for score_display_ctrl.
// Revision: 1.0
//============================================================================
module tb_score_display_ctrl;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       goodColl = 1'b0;
   logic       badColl = 1'b0;
   logic [7:0] currScore = 8'd0;
   logic [7:0] highScore = 8'd57;
   logic       tick = 1'b0;
   logic [3:0] bcd_ones, bcd_tens, bcd_hundreds;
   logic       blank, showing_high, busy, game_over;
   logic [11:0] digits;

   int errors = 0;
   int checks = 0;

`ifdef SCORE_FLASH_EN
   localparam bit FLASH_EN = 1'b1;
`else
   localparam bit FLASH_EN = 1'b0;
`endif

   assign digits = {bcd_hundreds, bcd_tens, bcd_ones};

   always #5 clk = ~clk;

   score_display_ctrl #(.HOLD_TICKS(6), .MAX_SCORE(140)) dut (
      .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl),
      .currScore(currScore), .highScore(highScore), .tick(tick),
      .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .bcd_hundreds(bcd_hundreds),
      .blank(blank), .showing_high(showing_high), .busy(busy),
      .game_over(game_over)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(); step(); step();
      checks++;
      if ({digits, blank, showing_high, busy, game_over} !== {12'h000, 4'b0100}) begin
         errors++;
         $display("FAIL reset_state: got digits=%h b=%b sh=%b busy=%b go=%b, want 000 0 1 0 0",
                  digits, blank, showing_high, busy, game_over);
      end
      nRst = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy c%0d: got %b want 1", i, busy);
         end
         if (i == 9) begin
            checks++;
            if (digits !== 12'h000) begin
               errors++;
               $display("FAIL reset_early_digits: got %h want 000", digits);
            end
         end
      end
      checks++;
      if (digits !== 12'h057 || showing_high !== 1'b1) begin
         errors++;
         $display("FAIL reset_conv: got %h sh=%b want 057 sh=1", digits, showing_high);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_pending();
      currScore = 8'd0;
      goodColl  = 1'b1;
      step();
      goodColl  = 1'b0;
      currScore = 8'd9;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 1) currScore = 8'd10;
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pending_busy c%0d: got %b want 1", i, busy);
         end
         if (i == 9 || i == 10 || i == 19 || i == 20) begin
            checks++;
            if (digits !== ((i == 9) ? 12'h057 : (i == 20) ? 12'h010 : 12'h009)) begin
               errors++;
               $display("FAIL pending_digits c%0d: got %h", i, digits);
            end
         end
      end
      checks++;
      if (showing_high !== 1'b0 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL pending_flags: got sh=%b go=%b want 0 0", showing_high, game_over);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL pending_done_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_flash_hold();
      currScore = 8'd23;
      goodColl  = 1'b1;
      badColl   = 1'b1;
      step();
      goodColl  = 1'b0;
      badColl   = 1'b0;
      checks++;
      if (game_over !== 1'b1 || blank !== 1'b0) begin
         errors++;
         $display("FAIL flash_entry: got go=%b blank=%b want 1 0", game_over, blank);
      end
      for (int i = 0; i < 24; i++) step();
      checks++;
      if (digits !== 12'h023 || showing_high !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flash_digits: got %h sh=%b busy=%b want 023 0 0", digits, showing_high, busy);
      end
      for (int k = 1; k <= 6; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         checks++;
         if (blank !== (FLASH_EN && (k % 2 == 1))) begin
            errors++;
            $display("FAIL flash_blank tick%0d: got %b want %b", k, blank, FLASH_EN && (k % 2 == 1));
         end
         checks++;
         if (busy !== 1'b0 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL flash_hold tick%0d: got busy=%b go=%b want 0 1", k, busy, game_over);
         end
         if (k < 6) step();
      end
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL high_entry_busy: got %b want 1", busy);
      end
      for (int i = 2; i <= 9; i++) step();
      checks++;
      if (digits !== 12'h023) begin
         errors++;
         $display("FAIL high_early_digits: got %h want 023", digits);
      end
      step();
      checks++;
      if (digits !== 12'h057 || showing_high !== 1'b1 || blank !== 1'b0 || game_over !== 1'b1) begin
         errors++;
         $display("FAIL high_state: got %h sh=%b b=%b go=%b want 057 1 0 1",
                  digits, showing_high, blank, game_over);
      end
   endtask

   task automatic test_max_score();
      currScore = 8'd139;
      goodColl  = 1'b1;
      step();
      goodColl  = 1'b0;
      for (int i = 0; i < 12; i++) step();
      checks++;
      if (digits !== 12'h139 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL max_below: got %h go=%b want 139 0", digits, game_over);
      end
      currScore = 8'd140;
      step();
      checks++;
      if (game_over !== 1'b1) begin
         errors++;
         $display("FAIL max_flash_entry: got go=%b want 1", game_over);
      end
      for (int i = 0; i < 11; i++) step();
      checks++;
      if (digits !== 12'h140 || blank !== 1'b0 || showing_high !== 1'b0) begin
         errors++;
         $display("FAIL max_digits: got %h b=%b sh=%b want 140 0 0", digits, blank, showing_high);
      end
   endtask

   task automatic test_abort_and_reset();
      for (int i = 0; i < 10; i++) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      checks++;
      if (blank !== FLASH_EN) begin
         errors++;
         $display("FAIL abort_blank_on: got %b want %b", blank, FLASH_EN);
      end
      step();
      goodColl  = 1'b1;
      tick      = 1'b1;
      currScore = 8'd5;
      step();
      goodColl  = 1'b0;
      tick      = 1'b0;
      checks++;
      if (blank !== 1'b0 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL abort_play: got b=%b go=%b want 0 0", blank, game_over);
      end
      currScore = 8'd77;
      badColl   = 1'b1;
      step();
      badColl   = 1'b0;
      tick      = 1'b1;
      step();
      tick      = 1'b0;
      checks++;
      if (blank !== FLASH_EN || busy !== 1'b1) begin
         errors++;
         $display("FAIL midflash_state: got b=%b busy=%b want %b 1", blank, busy, FLASH_EN);
      end
      step();
      nRst = 1'b0;
      #1;
      checks++;
      if ({digits, blank, showing_high, busy, game_over} !== {12'h000, 4'b0100}) begin
         errors++;
         $display("FAIL async_reset: got digits=%h b=%b sh=%b busy=%b go=%b, want 000 0 1 0 0",
                  digits, blank, showing_high, busy, game_over);
      end
      step();
      nRst = 1'b1;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (digits !== 12'h057 || showing_high !== 1'b1 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_conv: got %h sh=%b go=%b want 057 1 0", digits, showing_high, game_over);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pending();
      test_flash_hold();
      test_max_score();
      test_abort_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
